// File: rtl/key_process_multi_if.sv
// Key-pin bundle between the board pins and the multi-channel key processor.
// The master side drives the raw pins; the slave side returns levels and event pulses.
interface key_process_multi_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] btn_level_out;
  logic [CHANNELS-1:0] press_out;
  logic [CHANNELS-1:0] release_out;
  logic [CHANNELS-1:0] long_out;
  logic [CHANNELS-1:0] repeat_out;

  modport master (
    output btn_in,
    input  btn_level_out, press_out, release_out, long_out, repeat_out
  );

  modport slave (
    input  btn_in,
    output btn_level_out, press_out, release_out, long_out, repeat_out
  );
endinterface

// File: rtl/key_process_multi.sv
// Multi-channel key debouncer: shared 1 ms tick, per-channel debounce FSM with
// press/release, long-press and auto-repeat pulses plus a clean level.
module key_process_multi #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned FREQUENCY_IN = 100000,
  parameter int unsigned DEBOUNCE_MS  = 12,
  parameter int unsigned LONG_MS      = 1000,
  parameter int unsigned REPEAT_MS    = 200,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  key_process_multi_if.slave   key_if
);

  localparam int unsigned            PRE_W    = (FREQUENCY_IN > 1) ? $clog2(FREQUENCY_IN) : 1;
  localparam logic [PRE_W-1:0]       PRE_LAST = PRE_W'(FREQUENCY_IN - 1);
  localparam logic [15:0]            DEB_T    = 16'(DEBOUNCE_MS);
  localparam logic [15:0]            LONG_T   = 16'(LONG_MS);
  localparam logic [15:0]            REP_T    = 16'(REPEAT_MS);
  localparam logic [15:0]            CNT_MAX  = 16'hFFFF;
  localparam logic [CHANNELS-1:0]    IDLE_PIN = {CHANNELS{ACTIVE_LOW}};

  typedef enum logic [2:0] {
    IDLE,
    CHK_P,
    ACTIVE,
    HOLD,
    CHK_R
  } state_e;

  // Input conditioning: two-flop synchronizer, then normalise to 1 = pressed.
  logic [CHANNELS-1:0] sync1_q, sync2_q, act;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= IDLE_PIN;
      sync2_q <= IDLE_PIN;
    end else begin
      sync1_q <= key_if.btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign act = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Shared free-running prescaler; tick marks the last cycle of each millisecond.
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= pre_d;
  end

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [15:0]         cnt_q   [CHANNELS];
  logic [15:0]         cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] held_q, held_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CHANNELS-1:0] long_q, long_d;
  logic [CHANNELS-1:0] rep_q, rep_d;
  logic [CHANNELS-1:0] clr;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    rep_d     = '0;
    clr       = '0;

    for (int ch = 0; ch < CHANNELS; ch++) begin
      case (state_q[ch])
        IDLE: begin
          if (act[ch]) begin
            clr[ch]     = 1'b1;
            state_d[ch] = CHK_P;
          end
        end
        CHK_P: begin
          if (cnt_q[ch] == DEB_T) begin
            if (act[ch]) begin
              press_d[ch] = 1'b1;
              level_d[ch] = 1'b1;
              held_d[ch]  = 1'b0;
              clr[ch]     = 1'b1;
              state_d[ch] = ACTIVE;
            end else begin
              state_d[ch] = IDLE;
            end
          end
        end
        ACTIVE: begin
          if (!act[ch]) begin
            clr[ch]     = 1'b1;
            state_d[ch] = CHK_R;
          end else if (cnt_q[ch] == LONG_T) begin
            long_d[ch]  = 1'b1;
            held_d[ch]  = 1'b1;
            clr[ch]     = 1'b1;
            state_d[ch] = HOLD;
          end
        end
        HOLD: begin
          if (!act[ch]) begin
            clr[ch]     = 1'b1;
            state_d[ch] = CHK_R;
          end else if (REPEAT_EN && (cnt_q[ch] == REP_T)) begin
            rep_d[ch] = 1'b1;
            clr[ch]   = 1'b1;
          end
        end
        CHK_R: begin
          if (cnt_q[ch] == DEB_T) begin
            if (!act[ch]) begin
              release_d[ch] = 1'b1;
              level_d[ch]   = 1'b0;
              state_d[ch]   = IDLE;
            end else begin
              // Release glitch: resume holding with long/repeat timing restarted.
              clr[ch]     = 1'b1;
              state_d[ch] = held_q[ch] ? HOLD : ACTIVE;
            end
          end
        end
        default: state_d[ch] = IDLE;
      endcase

      // Clear wins over tick; saturation keeps thresholds from retriggering.
      if (clr[ch])                            cnt_d[ch] = '0;
      else if (tick && (cnt_q[ch] != CNT_MAX)) cnt_d[ch] = cnt_q[ch] + 16'd1;
    end
  end

  // NOTE: the per-channel state and counter arrays are control state, not bulk
  // storage, so they are reset along with everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        cnt_q[ch]   <= '0;
      end
      held_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
    end
  end

  assign key_if.btn_level_out = level_q;
  assign key_if.press_out     = press_q;
  assign key_if.release_out   = release_q;
  assign key_if.long_out      = long_q;
  assign key_if.repeat_out    = rep_q;

endmodule

// File: tb/tb_key_process_multi.sv
// Directed bench for key_process_multi: an active-low two-channel instance with
// auto-repeat and an active-high single-channel instance without it.
module tb_key_process_multi;

  localparam int FREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  key_process_multi_if #(.CHANNELS(2)) lo_if ();
  key_process_multi_if #(.CHANNELS(1)) hi_if ();

  key_process_multi #(
    .CHANNELS(2), .FREQUENCY_IN(FREQ), .DEBOUNCE_MS(3), .LONG_MS(10),
    .REPEAT_MS(4), .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1)
  ) u_lo (
    .clk(clk), .rst(rst), .key_if(lo_if)
  );

  key_process_multi #(
    .CHANNELS(1), .FREQUENCY_IN(FREQ), .DEBOUNCE_MS(3), .LONG_MS(10),
    .REPEAT_MS(4), .ACTIVE_LOW(1'b0), .REPEAT_EN(1'b0)
  ) u_hi (
    .clk(clk), .rst(rst), .key_if(hi_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle count and a reference model of the millisecond phase.
  int cyc = 0;
  int ph  = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst) begin
    if (!rst) ph <= 0;
    else      ph <= (ph == FREQ - 1) ? 0 : ph + 1;
  end

  // Pulse monitors, sampled on the falling edge.
  int press_cnt [2], release_cnt [2], long_cnt [2];
  int press_cyc [2], long_cyc [2];
  int rep_times [$];
  int both_press = 0;
  int width_err  = 0;
  int hi_press_cnt = 0, hi_release_cnt = 0, hi_long_cnt = 0, hi_rep_cnt = 0;
  int hi_press_cyc = 0, hi_long_cyc = 0;
  logic [7:0] prev_lo = '0;
  logic [3:0] prev_hi = '0;

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (lo_if.press_out[c])   begin press_cnt[c]++; press_cyc[c] = cyc; end
      if (lo_if.release_out[c]) release_cnt[c]++;
      if (lo_if.long_out[c])    begin long_cnt[c]++; long_cyc[c] = cyc; end
    end
    if (lo_if.repeat_out[1]) rep_times.push_back(cyc);
    if (lo_if.press_out == 2'b11) both_press++;
    if (hi_if.press_out[0])   begin hi_press_cnt++; hi_press_cyc = cyc; end
    if (hi_if.release_out[0]) hi_release_cnt++;
    if (hi_if.long_out[0])    begin hi_long_cnt++; hi_long_cyc = cyc; end
    if (hi_if.repeat_out[0])  hi_rep_cnt++;
    if ((({lo_if.press_out, lo_if.release_out, lo_if.long_out, lo_if.repeat_out}) & prev_lo) != '0)
      width_err++;
    if ((({hi_if.press_out, hi_if.release_out, hi_if.long_out, hi_if.repeat_out}) & prev_hi) != '0)
      width_err++;
    prev_lo = {lo_if.press_out, lo_if.release_out, lo_if.long_out, lo_if.repeat_out};
    prev_hi = {hi_if.press_out, hi_if.release_out, hi_if.long_out, hi_if.repeat_out};
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_press"},   lo_if.press_out,     2'b00);
    check({tag, "_release"}, lo_if.release_out,   2'b00);
    check({tag, "_long"},    lo_if.long_out,      2'b00);
    check({tag, "_repeat"},  lo_if.repeat_out,    2'b00);
    check({tag, "_level"},   lo_if.btn_level_out, 2'b00);
    check({tag, "_hi_out"},  {hi_if.btn_level_out, hi_if.press_out, hi_if.long_out}, 3'b000);
  endtask

  initial begin
    int k, p, g, n0, n1, l0, r0, rl0, lat, bp0;

    lo_if.btn_in = 2'b11;
    hi_if.btn_in = 1'b0;
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) step();
    check_all_zero("reset_held");
    rst = 1'b1;
    repeat (10) step();

    // 1. Clean press on channel 0, held for 100 cycles, then released.
    n0 = press_cnt[0];
    lo_if.btn_in[0] = 1'b0;
    k = cyc;
    repeat (100) step();
    check("t1_press_cnt", press_cnt[0] - n0, 1);
    lat = press_cyc[0] - k;
    check("t1_latency_in_range", (lat >= 10) && (lat <= 16), 1);
    check("t1_level", lo_if.btn_level_out[0], 1'b1);
    check("t1_no_release", release_cnt[0], 0);
    lo_if.btn_in[0] = 1'b1;
    repeat (30) step();
    check("t1_release_cnt", release_cnt[0], 1);
    check("t1_level_after", lo_if.btn_level_out[0], 1'b0);

    // 2. Bounce: 3-cycle toggles starting on a tick-phase-0 cycle never settle.
    n0 = press_cnt[0];
    do step(); while (ph != 0);
    for (int s = 0; s < 10; s++) begin
      lo_if.btn_in[0] = (s % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) step();
    end
    repeat (40) step();
    check("t2_no_press", press_cnt[0] - n0, 0);
    check("t2_level", lo_if.btn_level_out[0], 1'b0);

    // 3. Long press and auto-repeat on channel 1, released 160 cycles after press.
    n1 = press_cnt[1];
    l0 = long_cnt[1];
    rl0 = release_cnt[1];
    r0 = rep_times.size();
    lo_if.btn_in[1] = 1'b0;
    for (int i = 0; i < 40 && press_cnt[1] == n1; i++) step();
    check("t3_press_cnt", press_cnt[1] - n1, 1);
    p = press_cyc[1];
    while (cyc < p + 160) step();
    check("t3_level_held", lo_if.btn_level_out[1], 1'b1);
    lo_if.btn_in[1] = 1'b1;
    repeat (60) step();
    check("t3_long_cnt", long_cnt[1] - l0, 1);
    check("t3_long_delay", long_cyc[1] - p, 40);
    check("t3_repeat_cnt", rep_times.size() - r0, 7);
    if (rep_times.size() > r0) check("t3_first_repeat", rep_times[r0] - long_cyc[1], 16);
    for (int i = r0 + 1; i < rep_times.size(); i++)
      check("t3_repeat_gap", rep_times[i] - rep_times[i-1], 16);
    check("t3_release_cnt", release_cnt[1] - rl0, 1);
    check("t3_level_after", lo_if.btn_level_out[1], 1'b0);

    // 4. Release glitch while in HOLD is rejected; repeat timing restarts.
    n1 = press_cnt[1];
    l0 = long_cnt[1];
    lo_if.btn_in[1] = 1'b0;
    for (int i = 0; i < 40 && press_cnt[1] == n1; i++) step();
    for (int i = 0; i < 60 && long_cnt[1] == l0; i++) step();
    check("t4_long_cnt", long_cnt[1] - l0, 1);
    r0 = rep_times.size();
    for (int i = 0; i < 40 && rep_times.size() == r0; i++) step();
    check("t4_repeat_seen", rep_times.size() - r0, 1);
    do step(); while (ph != 0);
    g = cyc;
    rl0 = release_cnt[1];
    r0 = rep_times.size();
    lo_if.btn_in[1] = 1'b1;
    repeat (5) step();
    lo_if.btn_in[1] = 1'b0;
    for (int i = 0; i < 50 && rep_times.size() == r0; i++) step();
    check("t4_repeat_after_glitch", rep_times.size() - r0, 1);
    if (rep_times.size() > r0) check("t4_repeat_time", rep_times[r0] - g, 29);
    check("t4_no_release", release_cnt[1] - rl0, 0);
    check("t4_level", lo_if.btn_level_out[1], 1'b1);
    lo_if.btn_in[1] = 1'b1;
    repeat (30) step();
    check("t4_release_cnt", release_cnt[1] - rl0, 1);

    // 5. Simultaneous press, asynchronous reset mid-HOLD, fresh press after reset.
    bp0 = both_press;
    n0 = press_cnt[0];
    n1 = press_cnt[1];
    lo_if.btn_in = 2'b00;
    for (int i = 0; i < 40 && (press_cnt[0] == n0 || press_cnt[1] == n1); i++) step();
    check("t5_both_press", both_press - bp0, 1);
    repeat (60) step();
    check("t5_level_held", lo_if.btn_level_out, 2'b11);
    #2 rst = 1'b0;
    #1 check_all_zero("t5_async_reset");
    repeat (3) step();
    rst = 1'b1;
    bp0 = both_press;
    n0 = press_cnt[0];
    n1 = press_cnt[1];
    for (int i = 0; i < 40 && (press_cnt[0] == n0 || press_cnt[1] == n1); i++) step();
    check("t5_fresh_press", both_press - bp0, 1);
    check("t5_level_again", lo_if.btn_level_out, 2'b11);
    lo_if.btn_in = 2'b11;
    repeat (30) step();
    check("t5_level_released", lo_if.btn_level_out, 2'b00);

    // 6. Active-high instance without repeat: press, long, never a repeat.
    n0 = hi_press_cnt;
    l0 = hi_long_cnt;
    hi_if.btn_in = 1'b1;
    for (int i = 0; i < 40 && hi_press_cnt == n0; i++) step();
    check("t6_press_cnt", hi_press_cnt - n0, 1);
    repeat (100) step();
    check("t6_long_cnt", hi_long_cnt - l0, 1);
    check("t6_long_delay", hi_long_cyc - hi_press_cyc, 40);
    check("t6_no_repeat", hi_rep_cnt, 0);
    check("t6_level", hi_if.btn_level_out[0], 1'b1);
    hi_if.btn_in = 1'b0;
    repeat (30) step();
    check("t6_release_cnt", hi_release_cnt, 1);
    check("t6_level_after", hi_if.btn_level_out[0], 1'b0);

    check("pulse_width_one_cycle", width_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
